// File: rtl/input_cond_pkg.sv
// Shared types and defaults for the key/switch input conditioning front end.
package input_cond_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} db_state_t;

    // 1 ms at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/debounce_fsm.sv
// Single-key conditioner: 2-flop synchronizer on the active-high pressed
// signal, then a press/release debounce FSM emitting a level and a press strobe.
module debounce_fsm
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw_n,
    output logic pulse,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;
    db_state_t     state;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= ~raw_n;
            s2 <= s1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s2) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // Bouncing back high during release keeps the key held without a new strobe
                    if (s2) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        level = (state == HELD) || (state == RELEASE_WAIT);
    end

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: debounced key levels/press strobes and
// synchronized (not debounced) slide switches for the multiplier processor.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SW_WIDTH        = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                ClearALoadB_raw,
    input  logic                Execute_raw,
    input  logic [SW_WIDTH-1:0] Switches_raw,
    output logic [SW_WIDTH-1:0] Switches_S,
    output logic                ClearALoadB_pulse,
    output logic                Execute_pulse,
    output logic                ClearALoadB_level,
    output logic                Execute_level
);

    logic [SW_WIDTH-1:0] sw_s1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sw_s1      <= '0;
            Switches_S <= '0;
        end else begin
            sw_s1      <= Switches_raw;
            Switches_S <= sw_s1;
        end
    end

    debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .Clk   (Clk),
        .Reset (Reset),
        .raw_n (ClearALoadB_raw),
        .pulse (ClearALoadB_pulse),
        .level (ClearALoadB_level)
    );

    debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_execute_db (
        .Clk   (Clk),
        .Reset (Reset),
        .raw_n (Execute_raw),
        .pulse (Execute_pulse),
        .level (Execute_level)
    );

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4: vector table,
// directed corner sequences and random stimulus against a run-length reference model.
module tb_input_conditioner;

    localparam int D = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       ClearALoadB_raw = 1'b1;
    logic       Execute_raw = 1'b1;
    logic [7:0] Switches_raw = '0;
    logic [7:0] Switches_S;
    logic       ClearALoadB_pulse, Execute_pulse, ClearALoadB_level, Execute_level;

    input_conditioner #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(8)) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .ClearALoadB_raw   (ClearALoadB_raw),
        .Execute_raw       (Execute_raw),
        .Switches_raw      (Switches_raw),
        .Switches_S        (Switches_S),
        .ClearALoadB_pulse (ClearALoadB_pulse),
        .Execute_pulse     (Execute_pulse),
        .ClearALoadB_level (ClearALoadB_level),
        .Execute_level     (Execute_level)
    );

    always #5 Clk = ~Clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Reference model, index 0 = ClearALoadB, 1 = Execute. A key's accepted level
    // flips once the synchronized pressed value has disagreed with it for D+1 edges.
    logic       m_s1[2], m_s2[2], m_lvl[2], m_pulse[2];
    int         m_run[2];
    logic [7:0] m_sw1, m_sw;

    typedef struct {
        logic       exe_n;
        logic [7:0] sw;
        logic       exe_pulse;
        logic       exe_level;
        logic [7:0] sw_s;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_pulse[i] = 0; m_run[i] = 0;
        end
        m_sw1 = '0;
        m_sw  = '0;
    endtask

    task automatic model_edge();
        logic raw_n[2];
        raw_n[0] = ClearALoadB_raw;
        raw_n[1] = Execute_raw;
        for (int i = 0; i < 2; i++) begin
            m_run[i]   = (m_s2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
            m_pulse[i] = 0;
            if (m_run[i] == D + 1) begin
                m_lvl[i]   = ~m_lvl[i];
                m_run[i]   = 0;
                m_pulse[i] = m_lvl[i];
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = ~raw_n[i];
        end
        m_sw  = m_sw1;
        m_sw1 = Switches_raw;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
        if (!Reset) model_reset();
        else model_edge();
        chk("sw_s", Switches_S, m_sw);
        chk("clr_pulse", ClearALoadB_pulse, m_pulse[0]);
        chk("clr_level", ClearALoadB_level, m_lvl[0]);
        chk("exe_pulse", Execute_pulse, m_pulse[1]);
        chk("exe_level", Execute_level, m_lvl[1]);
    endtask

    initial begin
        int np_c, np_e, at_c, at_e, lvl_lo, lvl_hi;

        // Clean press at edge 0, release at edge 10, switch changes at edges 2 and 12
        for (int i = 0; i < 17; i++) begin
            tbl[i].exe_n     = !(i < 10);
            tbl[i].sw        = (i < 2) ? 8'h00 : (i < 12) ? 8'h3C : 8'h5A;
            tbl[i].exe_pulse = (i == 6);
            tbl[i].exe_level = (i >= 6) && (i < 16);
            tbl[i].sw_s      = (i < 3) ? 8'h00 : (i < 13) ? 8'h3C : 8'h5A;
        end

        model_reset();
        step();
        step();
        chk("reset_sw_s", Switches_S, 0);
        chk("reset_exe_level", Execute_level, 0);
        Reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            Execute_raw  = tbl[i].exe_n;
            Switches_raw = tbl[i].sw;
            step();
            chk($sformatf("tbl%0d_exe_pulse", i), Execute_pulse, tbl[i].exe_pulse);
            chk($sformatf("tbl%0d_exe_level", i), Execute_level, tbl[i].exe_level);
            chk($sformatf("tbl%0d_sw_s", i), Switches_S, tbl[i].sw_s);
            chk($sformatf("tbl%0d_clr_level", i), ClearALoadB_level, 0);
        end

        // Bounce: low 3, high 1, low 2, then high
        np_e = 0; lvl_hi = 0;
        for (int i = 0; i < 18; i++) begin
            Execute_raw = (i == 3 || i >= 6);
            step();
            np_e   += Execute_pulse;
            lvl_hi += Execute_level;
        end
        chk("bounce_pulses", np_e, 0);
        chk("bounce_level_cycles", lvl_hi, 0);

        // Release chatter while held
        np_e = 0;
        Execute_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); np_e += Execute_pulse; end
        chk("chatter_first_pulse", np_e, 1);
        np_e = 0; lvl_lo = 0;
        for (int i = 0; i < 14; i++) begin
            Execute_raw = !(i < 2) ? 1'b0 : 1'b1;
            step();
            np_e   += Execute_pulse;
            lvl_lo += !Execute_level;
        end
        chk("chatter_extra_pulses", np_e, 0);
        chk("chatter_level_drops", lvl_lo, 0);
        Execute_raw = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("chatter_released", Execute_level, 0);

        // Simultaneous presses
        np_c = 0; np_e = 0; at_c = -1; at_e = -2;
        ClearALoadB_raw = 1'b0;
        Execute_raw     = 1'b0;
        Switches_raw    = 8'hA5;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ClearALoadB_pulse) begin np_c++; at_c = i; end
            if (Execute_pulse) begin np_e++; at_e = i; end
        end
        chk("simul_clr_pulses", np_c, 1);
        chk("simul_exe_pulses", np_e, 1);
        chk("simul_same_cycle", at_c, at_e);

        // Asynchronous reset mid-operation with keys held and switches at A5
        #2;
        Reset = 1'b0;
        #1;
        chk("async_sw_s", Switches_S, 0);
        chk("async_clr_level", ClearALoadB_level, 0);
        chk("async_exe_level", Execute_level, 0);
        chk("async_pulses", ClearALoadB_pulse + Execute_pulse, 0);
        model_reset();
        step();
        step();
        Reset = 1'b1;
        np_c = 0; np_e = 0; at_c = -1; at_e = -1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (ClearALoadB_pulse) begin np_c++; at_c = i; end
            if (Execute_pulse) begin np_e++; at_e = i; end
        end
        chk("rst_release_clr_pulses", np_c, 1);
        chk("rst_release_exe_pulses", np_e, 1);
        chk("rst_release_clr_edge", at_c, 6);
        chk("rst_release_exe_edge", at_e, 6);

        ClearALoadB_raw = 1'b1;
        Execute_raw     = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Random key activity and switch values
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(7) == 0) ClearALoadB_raw = ~ClearALoadB_raw;
            if ($urandom_range(7) == 0) Execute_raw = ~Execute_raw;
            if ($urandom_range(3) == 0) Switches_raw = 8'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
